// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : unified_mem_arbiter
// Brief   : Shares one single-port synchronous RAM between the instruction
//           fetch (IF) and memory-access (MA) stages. The data side wins by
//           default, and a starvation counter forces a fetch grant after a
//           bounded run of denials. Read data returns one cycle after grant
//           and is steered to the requester that owns it.
// Revision: 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_FETCH_STARVE = 4
) (
    input  logic                    sysclk,
    input  logic                    cpu_resetn,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    ma_req,
    input  logic                    ma_we,
    input  logic [DATA_WIDTH/8-1:0] ma_be,
    input  logic [ADDR_WIDTH-1:0]   ma_addr,
    input  logic [DATA_WIDTH-1:0]   ma_wdata,
    output logic                    ma_gnt,
    output logic                    ma_rvalid,
    output logic [DATA_WIDTH-1:0]   ma_rdata,

    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    // Counter must be able to hold the saturation value itself.
    localparam int CNT_WIDTH = (MAX_FETCH_STARVE < 1) ? 1 : $clog2(MAX_FETCH_STARVE + 1);
    localparam logic [CNT_WIDTH-1:0] c_starve_max = CNT_WIDTH'(MAX_FETCH_STARVE);

    // Who owns the read data arriving from the RAM in the current cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        MA_RD = 2'd2
    } owner_t;

    owner_t               r_owner;
    logic [CNT_WIDTH-1:0] r_starve_cnt;
    logic                 w_fetch_prio;

    // Fetch only overrides the data side once it has been denied long enough.
    assign w_fetch_prio = (r_starve_cnt == c_starve_max);
    assign ma_gnt       = ma_req & ~(w_fetch_prio & if_req);
    assign if_gnt       = if_req & ~ma_gnt;

    // RAM port is driven straight from the winning requester.
    assign mem_en    = if_gnt | ma_gnt;
    assign mem_addr  = ma_gnt ? ma_addr : if_addr;
    assign mem_we    = (ma_gnt & ma_we) ? ma_be : {BE_WIDTH{1'b0}};
    assign mem_wdata = ma_wdata;

    // Responses are steered by the registered owner; data is zeroed when not valid.
    assign if_rvalid = (r_owner == IF_RD);
    assign ma_rvalid = (r_owner == MA_RD);
    assign if_rdata  = if_rvalid ? mem_rdata : {DATA_WIDTH{1'b0}};
    assign ma_rdata  = ma_rvalid ? mem_rdata : {DATA_WIDTH{1'b0}};

    // Count consecutive denied fetch cycles, saturating; any grant or idle fetch clears it.
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            r_starve_cnt <= '0;
        end else if (if_req & ~if_gnt) begin
            if (r_starve_cnt != c_starve_max) begin
                r_starve_cnt <= r_starve_cnt + CNT_WIDTH'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Owner FSM: records which read was issued so its data can be tagged next cycle.
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            r_owner <= IDLE;
        end else begin
            if (if_gnt) begin
                r_owner <= IF_RD;
            end else if (ma_gnt & ~ma_we) begin
                r_owner <= MA_RD;
            end else begin
                r_owner <= IDLE;
            end
        end
    end

endmodule
`default_nettype wire
